// File: rtl/seq_detect_param_if.sv
// Bus bundle for the parametrised serial sequence detector.
// Stream, pattern/mask controls and match status.
interface seq_detect_param_if #(
   parameter int N  = 4,
   parameter int CW = 8
);
   logic          x_valid;
   logic          x;
   logic [N-1:0]  pattern;
   logic [N-1:0]  mask;
   logic          overlap;
   logic          clear_cnt;
   logic          z;
   logic [CW-1:0] match_count;
   logic          cnt_sat;

   modport master (
      output x_valid, x, pattern, mask, overlap, clear_cnt,
      input  z, match_count, cnt_sat
   );

   modport slave (
      input  x_valid, x, pattern, mask, overlap, clear_cnt,
      output z, match_count, cnt_sat
   );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector with masked compare,
// overlap select and a saturating match counter.
module seq_detect_param #(
   parameter int N  = 4,
   parameter int CW = 8
) (
   input logic               clk,
   input logic               reset,
   seq_detect_param_if.slave bus
);
   localparam int FW = $clog2(N + 1);
   localparam logic [FW-1:0] FULL = FW'(N);
   localparam logic [CW-1:0] CMAX = {CW{1'b1}};

   logic [N-1:0]  hist_q, hist_d;
   logic [FW-1:0] fill_q, fill_d;
   logic [FW-1:0] fill_nx;
   logic          z_q, z_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sat_q, sat_d;
   logic          match;

   // Shift in qualified bits, track fill level and detect a match.
   always_comb begin
      hist_d  = hist_q;
      fill_d  = fill_q;
      fill_nx = fill_q;
      match   = 1'b0;
      if (bus.x_valid) begin
         hist_d  = {hist_q[N-2:0], bus.x};
         fill_nx = (fill_q == FULL) ? FULL : fill_q + 1'b1;
         match   = (fill_nx == FULL) &&
                   (((hist_d ^ bus.pattern) & bus.mask) == '0);
         fill_d  = (match && !bus.overlap) ? '0 : fill_nx;
      end
   end

   // Saturating counter; a clear beats a simultaneous match.
   always_comb begin
      cnt_d = cnt_q;
      sat_d = sat_q;
      z_d   = match;
      if (bus.clear_cnt) begin
         cnt_d = '0;
         sat_d = 1'b0;
      end else if (match && cnt_q != CMAX) begin
         cnt_d = cnt_q + 1'b1;
         sat_d = (cnt_d == CMAX);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q <= '0;
         fill_q <= '0;
         z_q    <= 1'b0;
         cnt_q  <= '0;
         sat_q  <= 1'b0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         z_q    <= z_d;
         cnt_q  <= cnt_d;
         sat_q  <= sat_d;
      end
   end

   assign bus.z           = z_q;
   assign bus.match_count = cnt_q;
   assign bus.cnt_sat     = sat_q;
endmodule
